// File: rtl/fc_pkg.sv
// Shared definitions for the fc layer post-processing blocks:
// the default layer width, the bias word type and a signed clamp helper.
package fc_pkg;

    localparam int FC_T = 12;

    typedef logic signed [FC_T-1:0] bias_t;

    // Clamp a sign-extended value into the signed range of a width-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                      input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (val > hi) begin
            return hi;
        end
        if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/fc_bias_rom.sv
// Per-neuron bias table for the fc layer, emitted by the layer generator.
// Unused addresses read as zero.
module fc_bias_rom
    import fc_pkg::*;
#(
    parameter int M  = 6,
    parameter int T  = FC_T,
    localparam int AW = (M > 1) ? $clog2(M) : 1
) (
    input  logic [AW-1:0]       addr,
    output logic signed [T-1:0] z
);

    bias_t word;

    always_comb begin
        word = '0;
        case (int'(addr))
            0:       word = bias_t'(5);
            1:       word = bias_t'(-3);
            2:       word = bias_t'(0);
            3:       word = bias_t'(10);
            4:       word = bias_t'(-7);
            5:       word = bias_t'(2);
            default: word = '0;
        endcase
        z = T'(word);
    end

endmodule

// File: rtl/fc_bias_relu_stage.sv
// Bias-add, optional ReLU, arithmetic shift and saturation on the fc output stream,
// as a 2-stage elastic pipeline with last-of-vector marking.
module fc_bias_relu_stage
    import fc_pkg::*;
#(
    parameter int M     = 6,
    parameter int T     = FC_T,
    parameter int OT    = 8,
    parameter int SHIFT = 2,
    parameter int RELU  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic signed [T-1:0]  input_data,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic signed [OT-1:0] output_data,
    output logic                 output_last,
    output logic                 sat_sticky
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int SW = T + 1;

    logic [IW-1:0]        idx;
    logic signed [T-1:0]  bias;

    logic                 s1_v;
    logic signed [SW-1:0] s1_sum;
    logic                 s1_last;

    logic                 out_v;
    logic signed [OT-1:0] out_data;
    logic                 out_last;
    logic                 sat;

    logic                 adv2;
    logic                 accept;

    logic signed [SW-1:0] relu_val;
    logic signed [SW-1:0] shifted;
    logic signed [63:0]   wide;
    logic signed [63:0]   clamped;
    logic                 clamp_hit;

    fc_bias_rom #(
        .M(M),
        .T(T)
    ) u_bias_rom (
        .addr(idx),
        .z   (bias)
    );

    // S1 may be refilled in the same cycle it drains into S2.
    assign adv2        = s1_v && (!out_v || output_ready);
    assign input_ready = !s1_v || adv2;
    assign accept      = input_valid && input_ready;

    always_comb begin
        relu_val  = ((RELU != 0) && (s1_sum < 0)) ? '0 : s1_sum;
        shifted   = relu_val >>> SHIFT;
        wide      = {{(64 - SW){shifted[SW-1]}}, shifted};
        clamped   = sat_signed(wide, OT);
        clamp_hit = (clamped != wide);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx      <= '0;
            s1_v     <= 1'b0;
            s1_sum   <= '0;
            s1_last  <= 1'b0;
            out_v    <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            sat      <= 1'b0;
        end else begin
            if (accept) begin
                idx     <= (idx == IW'(M - 1)) ? '0 : idx + 1'b1;
                s1_v    <= 1'b1;
                s1_sum  <= {input_data[T-1], input_data} + {bias[T-1], bias};
                s1_last <= (idx == IW'(M - 1));
            end else if (adv2) begin
                s1_v <= 1'b0;
            end

            if (adv2) begin
                out_v    <= 1'b1;
                out_data <= clamped[OT-1:0];
                out_last <= s1_last;
                if (clamp_hit) begin
                    sat <= 1'b1;
                end
            end else if (output_ready) begin
                out_v <= 1'b0;
            end
        end
    end

    assign output_valid = out_v;
    assign output_data  = out_data;
    assign output_last  = out_last;
    assign sat_sticky   = sat;

endmodule

// File: tb/tb_fc_bias_relu_stage.sv
// Bench for fc_bias_relu_stage: one ReLU and one pass-through instance share a stream;
// a queue of expected outputs is filled on accept and drained as outputs transfer.
module tb_fc_bias_relu_stage;

    typedef struct packed {
        logic signed [7:0] d1;
        logic signed [7:0] d0;
        logic              last;
        logic              s1;
        logic              s0;
    } exp_t;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              iv    = 1'b0;
    logic              ordy  = 1'b1;
    logic signed [11:0] id   = '0;

    logic              rdy1, rdy0, ov1, ov0, ol1, ol0, ss1, ss0;
    logic signed [7:0] od1, od0;

    int                total = 0;
    int                bad   = 0;
    exp_t              q[$];
    exp_t              e;
    int unsigned       midx  = 0;
    logic              msat1 = 1'b0;
    logic              msat0 = 1'b0;
    logic              hold_prev = 1'b0;
    logic signed [7:0] held1, held0;
    logic              held_last;
    int                bias_tab[6] = '{5, -3, 0, 10, -7, 2};
    int                vals[7]     = '{40, -12, 300, -100, 600, 7, -30};

    always #5 clk = ~clk;

    fc_bias_relu_stage #(.M(6), .T(12), .OT(8), .SHIFT(2), .RELU(1)) u_relu (
        .clk(clk), .reset(rst_n), .input_valid(iv), .input_ready(rdy1), .input_data(id),
        .output_valid(ov1), .output_ready(ordy), .output_data(od1), .output_last(ol1),
        .sat_sticky(ss1)
    );

    fc_bias_relu_stage #(.M(6), .T(12), .OT(8), .SHIFT(2), .RELU(0)) u_pass (
        .clk(clk), .reset(rst_n), .input_valid(iv), .input_ready(rdy0), .input_data(id),
        .output_valid(ov0), .output_ready(ordy), .output_data(od0), .output_last(ol0),
        .sat_sticky(ss0)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp8(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    function automatic exp_t model(input int d, input int unsigned k);
        exp_t r;
        int   sum, pos, sh1, sh0;
        sum  = d + bias_tab[k];
        pos  = (sum < 0) ? 0 : sum;
        sh1  = pos >>> 2;
        sh0  = sum >>> 2;
        r.d1   = 8'(clamp8(sh1));
        r.d0   = 8'(clamp8(sh0));
        r.last = (k == 5);
        r.s1   = (sh1 > 127) || (sh1 < -128);
        r.s0   = (sh0 > 127) || (sh0 < -128);
        return r;
    endfunction

    function automatic exp_t mk(input int d1, input int d0, input logic last,
                                input logic s1, input logic s0);
        exp_t r;
        r.d1 = 8'(d1); r.d0 = 8'(d0); r.last = last; r.s1 = s1; r.s0 = s0;
        return r;
    endfunction

    task automatic drive(input logic v, input logic signed [11:0] d, input logic r,
                         output logic acc);
        iv = v; id = d; ordy = r;
        #1;
        acc = v && rdy1;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push_acc(input exp_t x);
        q.push_back(x);
        midx = (midx == 5) ? 0 : midx + 1;
    endtask

    task automatic send(input logic signed [11:0] d, input exp_t x, input logic use_model);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            drive(1'b1, d, 1'b1, acc);
            if (acc) push_acc(use_model ? model(int'(d), midx) : x);
            tick();
        end
        iv = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain;
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                chk("hold_data1", od1, held1);
                chk("hold_data0", od0, held0);
                chk("hold_last", ol1, held_last);
            end
            if (ov1 && ordy) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data_relu", od1, e.d1);
                    chk("data_pass", od0, e.d0);
                    chk("last_relu", ol1, e.last);
                    chk("last_pass", ol0, e.last);
                    chk("valid_pass", ov0, 1);
                    msat1 = msat1 | e.s1;
                    msat0 = msat0 | e.s0;
                    chk("sticky_relu", ss1, msat1);
                    chk("sticky_pass", ss0, msat0);
                end
            end
            hold_prev = ov1 && !ordy;
            held1     = od1;
            held0     = od0;
            held_last = ol1;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n;
        logic signed [11:0] d;

        rst_n = 1'b0; iv = 1'b0; ordy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_valid1", ov1, 0);
        chk("rst_valid0", ov0, 0);
        chk("rst_data", od1, 0);
        chk("rst_last", ol1, 0);
        chk("rst_sticky1", ss1, 0);
        chk("rst_sticky0", ss0, 0);
        chk("rst_ready", rdy1, 1);

        // vector A: ReLU zeroing, floor shift, pass-through saturation at idx4 only
        send(12'sd100,  mk(26, 26, 0, 0, 0), 1'b0);
        send(-12'sd50,  mk(0, -14, 0, 0, 0), 1'b0);
        send(-12'sd9,   mk(0, -3, 0, 0, 0), 1'b0);
        send(12'sd0,    mk(2, 2, 0, 0, 0), 1'b0);
        send(-12'sd600, mk(0, -128, 0, 0, 1), 1'b0);
        send(12'sd20,   mk(5, 5, 1, 0, 0), 1'b0);
        drain();
        chk("sticky_A_relu", ss1, 0);
        chk("sticky_A_pass", ss0, 1);

        // vector B: positive saturation at idx3 on both instances
        send(12'sd0,    mk(1, 1, 0, 0, 0), 1'b0);
        send(12'sd3,    mk(0, 0, 0, 0, 0), 1'b0);
        send(12'sd7,    mk(1, 1, 0, 0, 0), 1'b0);
        send(12'sd2000, mk(127, 127, 0, 1, 1), 1'b0);
        send(12'sd28,   mk(5, 5, 0, 0, 0), 1'b0);
        send(-12'sd2,   mk(0, 0, 1, 0, 0), 1'b0);
        drain();
        chk("sticky_B_relu", ss1, 1);

        // backpressure: output_ready low for 5 cycles while streaming 7 inputs
        n = 0;
        for (int c = 0; c < 14; c++) begin
            d = (n < 7) ? 12'(vals[n]) : 12'sd0;
            drive(n < 7, d, c >= 5, acc);
            if (c >= 2 && c < 5) chk("bp_ready_low", rdy1, 0);
            if (c == 5) chk("bp_accepts", n, 2);
            if (c >= 5 && c <= 11) chk("stream_rate", ov1, 1);
            if (acc) begin
                push_acc(model(int'(d), midx));
                n++;
            end
            tick();
        end
        iv = 1'b0;
        drain();
        chk("stream_count", n, 7);
        chk("sticky_kept", ss1, 1);

        // reset mid-vector discards in-flight data and restarts at idx0
        send(12'sd11, mk(0, 0, 0, 0, 0), 1'b1);
        send(12'sd22, mk(0, 0, 0, 0, 0), 1'b1);
        send(12'sd33, mk(0, 0, 0, 0, 0), 1'b1);
        rst_n = 1'b0;
        iv    = 1'b0;
        q.delete();
        midx  = 0;
        msat1 = 1'b0;
        msat0 = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_valid1", ov1, 0);
        chk("midrst_valid0", ov0, 0);
        chk("midrst_sticky", ss1, 0);
        chk("midrst_ready", rdy1, 1);
        send(12'sd40, mk(11, 11, 0, 0, 0), 1'b0);
        drain();
        repeat (3) tick();
        chk("idle_valid", ov1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
